rv32i_mem_arbiter: RTL and testbench

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/rv32i_mem_arbiter_if.sv | 54 +++++
 rtl/rv32i_mem_arbiter.sv | 103 ++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: memory op encoding plus the memory arbiter's
// FSM state and source-select enums.
package rv32i;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_SRC_IF = 1'b0,
    ARB_SRC_D  = 1'b1
  } arb_src_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Memory is word addressed; the low two address bits never reach the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port of the
// arbiter. 'slave' is the arbiter's view, 'master' the view of everything
// around it (fetch unit, LSU and memory).
interface rv32i_mem_arbiter_if;
  import rv32i::*;

  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  // data port
  logic        d_req;
  mem_op_e     d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  // memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_op, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_op, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Two-source (fetch / data) arbiter onto a single memory port with one
// outstanding transaction, round-robin on conflict, and a response timeout
// that turns a missing mem_rvalid into an error response.
module rv32i_mem_arbiter
  import rv32i::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  rv32i_mem_arbiter_if.slave bus
);

  // A zero TIMEOUT still needs a legal counter width even though it is unused.
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            TMO_EN   = (TIMEOUT > 0);

  arb_state_e    state;
  arb_src_e      last_src;
  arb_src_e      sel_src;
  logic [CW-1:0] cnt;

  logic issue, accept, waiting, tmo, done, rsp_d;
  logic [31:0] rsp_rdata;

  // Round-robin pick: a lone requester wins, a conflict goes to whoever
  // was not granted last.
  always_comb begin
    sel_src = ARB_SRC_IF;
    if (bus.if_req && bus.d_req)
      sel_src = (last_src == ARB_SRC_IF) ? ARB_SRC_D : ARB_SRC_IF;
    else if (bus.d_req)
      sel_src = ARB_SRC_D;
  end

  // Requests are only offered to memory from idle; reset masks everything.
  assign issue  = !rst && (state == ARB_IDLE) && (bus.if_req || bus.d_req);
  assign accept = issue && bus.mem_gnt;

  assign bus.if_gnt = accept && (sel_src == ARB_SRC_IF);
  assign bus.d_gnt  = accept && (sel_src == ARB_SRC_D);

  // Memory request fields follow the selected source; all zero when idle.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (issue) begin
      bus.mem_req = 1'b1;
      if (sel_src == ARB_SRC_D) begin
        bus.mem_we    = (bus.d_op == MEM_STORE);
        bus.mem_addr  = word_addr(bus.d_addr);
        bus.mem_wdata = bus.d_wdata;
        bus.mem_be    = bus.d_be;
      end else begin
        bus.mem_addr  = word_addr(bus.if_addr);
        bus.mem_be    = BE_WORD;
      end
    end
  end

  // Response side: a real mem_rvalid always beats a coincident timeout.
  assign waiting   = !rst && (state != ARB_IDLE);
  assign tmo       = TMO_EN && (cnt == TMO_LAST) && !bus.mem_rvalid;
  assign done      = waiting && (bus.mem_rvalid || tmo);
  assign rsp_d     = (state == ARB_WAIT_D);
  assign rsp_rdata = (waiting && bus.mem_rvalid) ? bus.mem_rdata : '0;

  assign bus.if_rvalid = done && !rsp_d;
  assign bus.if_rdata  = rsp_d ? '0 : rsp_rdata;
  assign bus.if_err    = done && tmo && !rsp_d;
  assign bus.d_rvalid  = done && rsp_d;
  assign bus.d_rdata   = rsp_d ? rsp_rdata : '0;
  assign bus.d_err     = done && tmo && rsp_d;

  // Arbiter FSM, round-robin history and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last_src <= ARB_SRC_IF;
      cnt      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            state    <= (sel_src == ARB_SRC_D) ? ARB_WAIT_D : ARB_WAIT_IF;
            last_src <= sel_src;
            cnt      <= '0;
          end
        end
        ARB_WAIT_IF, ARB_WAIT_D: begin
          if (done) state <= ARB_IDLE;
          else      cnt   <= cnt + CW'(1);
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed, table-driven bench for rv32i_mem_arbiter (TIMEOUT=4). Each
// vector is one clock: inputs driven at the falling edge, all outputs
// compared 1ns later, state advances on the following rising edge.
module tb_rv32i_mem_arbiter;
  import rv32i::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv32i_mem_arbiter_if bus();

  rv32i_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    mem_op_e     d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam mem_op_e L = MEM_LOAD;
  localparam mem_op_e S = MEM_STORE;

  function automatic in_t fi(logic r, logic ir, logic [31:0] ia, logic dr, mem_op_e op,
                             logic [31:0] da, logic [31:0] dw, logic [3:0] be,
                             logic g, logic rv, logic [31:0] rd);
    in_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_op = op;
    v.d_addr = da; v.d_wdata = dw; v.d_be = be;
    v.mem_gnt = g; v.mem_rvalid = rv; v.mem_rdata = rd;
    return v;
  endfunction

  function automatic out_t o_idle();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_issue(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                   logic ig, logic dg);
    out_t o;
    o = '0;
    o.mem_req = 1'b1; o.mem_we = we; o.mem_addr = a; o.mem_wdata = wd; o.mem_be = be;
    o.if_gnt = ig; o.d_gnt = dg;
    return o;
  endfunction

  function automatic out_t o_if(logic [31:0] rd, logic err);
    out_t o;
    o = '0;
    o.if_rvalid = 1'b1; o.if_rdata = rd; o.if_err = err;
    return o;
  endfunction

  function automatic out_t o_d(logic [31:0] rd, logic err);
    out_t o;
    o = '0;
    o.d_rvalid = 1'b1; o.d_rdata = rd; o.d_err = err;
    return o;
  endfunction

  function automatic void add(string n, in_t i, out_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    tbl.push_back(v);
  endfunction

  task automatic apply(input string nm, input int idx, input in_t i, input out_t e);
    out_t a;
    @(negedge clk);
    rst            = i.rst;
    bus.if_req     = i.if_req;
    bus.if_addr    = i.if_addr;
    bus.d_req      = i.d_req;
    bus.d_op       = i.d_op;
    bus.d_addr     = i.d_addr;
    bus.d_wdata    = i.d_wdata;
    bus.d_be       = i.d_be;
    bus.mem_gnt    = i.mem_gnt;
    bus.mem_rvalid = i.mem_rvalid;
    bus.mem_rdata  = i.mem_rdata;
    #1;
    a.mem_req   = bus.mem_req;
    a.mem_we    = bus.mem_we;
    a.mem_addr  = bus.mem_addr;
    a.mem_wdata = bus.mem_wdata;
    a.mem_be    = bus.mem_be;
    a.if_gnt    = bus.if_gnt;
    a.d_gnt     = bus.d_gnt;
    a.if_rvalid = bus.if_rvalid;
    a.if_rdata  = bus.if_rdata;
    a.if_err    = bus.if_err;
    a.d_rvalid  = bus.d_rvalid;
    a.d_rdata   = bus.d_rdata;
    a.d_err     = bus.d_err;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, a, e);
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_op = MEM_LOAD;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // reset: everything quiet even with both requests, gnt and rvalid high
    add("rst",   fi(1, 1, 32'h1006, 1, L, 32'h200, 0, 4'hF, 1, 1, 32'h1), o_idle());
    add("rst",   fi(1, 1, 32'h1006, 1, L, 32'h200, 0, 4'hF, 1, 1, 32'h1), o_idle());
    // single fetch, response in the third wait cycle, then a spurious rvalid
    add("fetch", fi(0, 1, 32'h1006, 0, L, 0, 0, 0, 1, 0, 0), o_issue(0, 32'h1004, 0, 4'hF, 1, 0));
    add("fetch", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_idle());
    add("fetch", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_idle());
    add("fetch", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'hDEAD_BEEF), o_if(32'hDEAD_BEEF, 0));
    add("spur",  fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'h5555_5555), o_idle());
    // both requesting continuously: D, IF, D, IF
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 0, 0), o_issue(0, 32'h2000, 32'hAAAA_5555, 4'hF, 0, 1));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 1, 32'h11), o_d(32'h11, 0));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 0, 0), o_issue(0, 32'h3000, 0, 4'hF, 1, 0));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 1, 32'h22), o_if(32'h22, 0));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 0, 0), o_issue(0, 32'h2000, 32'hAAAA_5555, 4'hF, 0, 1));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 1, 32'h33), o_d(32'h33, 0));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 0, 0), o_issue(0, 32'h3000, 0, 4'hF, 1, 0));
    add("rr",    fi(0, 1, 32'h3000, 1, L, 32'h2000, 32'hAAAA_5555, 4'hF, 1, 1, 32'h44), o_if(32'h44, 0));
    // partial-word store
    add("store", fi(0, 0, 0, 1, S, 32'h200, 32'h1234_5678, 4'b0011, 1, 0, 0), o_issue(1, 32'h200, 32'h1234_5678, 4'b0011, 0, 1));
    add("store", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 0), o_d(0, 0));
    // memory stalls the grant for five cycles
    for (int k = 0; k < 5; k++)
      add("stall", fi(0, 1, 32'h40, 0, L, 0, 0, 0, 0, 0, 0), o_issue(0, 32'h40, 0, 4'hF, 0, 0));
    add("stall", fi(0, 1, 32'h40, 0, L, 0, 0, 0, 1, 0, 0), o_issue(0, 32'h40, 0, 4'hF, 1, 0));
    add("stall", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'h77), o_if(32'h77, 0));
    // conflict with unaligned data address; no grant in the response cycle
    add("align", fi(0, 1, 32'h40, 1, L, 32'hFFF, 0, 4'hC, 1, 0, 0), o_issue(0, 32'hFFC, 0, 4'hC, 0, 1));
    add("align", fi(0, 1, 32'h40, 0, L, 0, 0, 0, 1, 1, 32'h99), o_d(32'h99, 0));
    add("align", fi(0, 1, 32'h40, 0, L, 0, 0, 0, 1, 0, 0), o_issue(0, 32'h40, 0, 4'hF, 1, 0));
    add("align", fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'h66), o_if(32'h66, 0));

    foreach (tbl[k]) apply(tbl[k].name, k, tbl[k].i, tbl[k].o);

    // timeout: load never answered, error in fourth wait cycle, late rvalid dropped
    apply("tmo", 0, fi(0, 0, 0, 1, L, 32'h100, 0, 4'hF, 1, 0, 0), o_issue(0, 32'h100, 0, 4'hF, 0, 1));
    for (int k = 1; k <= 3; k++)
      apply("tmo", k, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_idle());
    apply("tmo", 4, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_d(0, 1));
    apply("tmo", 5, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'hBAD0), o_idle());

    // rvalid arriving exactly at the timeout cycle is a normal response
    apply("race", 0, fi(0, 0, 0, 1, L, 32'h104, 0, 4'hF, 1, 0, 0), o_issue(0, 32'h104, 0, 4'hF, 0, 1));
    for (int k = 1; k <= 3; k++)
      apply("race", k, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_idle());
    apply("race", 4, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'h1234), o_d(32'h1234, 0));
    apply("race", 5, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 0, 0), o_idle());

    // reset while waiting on data: abandoned, following rvalid ignored,
    // round-robin history back to "data wins first conflict"
    apply("rstmid", 0, fi(0, 0, 0, 1, L, 32'h300, 0, 4'hF, 1, 0, 0), o_issue(0, 32'h300, 0, 4'hF, 0, 1));
    apply("rstmid", 1, fi(1, 1, 32'h40, 1, L, 32'h300, 0, 4'hF, 1, 1, 32'hABCD), o_idle());
    apply("rstmid", 2, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'hBAD), o_idle());
    apply("rstmid", 3, fi(0, 1, 32'h40, 1, L, 32'h300, 0, 4'hF, 1, 0, 0), o_issue(0, 32'h300, 0, 4'hF, 0, 1));
    apply("rstmid", 4, fi(0, 0, 0, 0, L, 0, 0, 0, 1, 1, 32'h5A), o_d(32'h5A, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
